// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding and sizing helpers for the memory access unit.
package mem_access_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;
   localparam int ERR_DATA = 0;
   function automatic int timeoutW(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data memory bus between the access unit (master) and memory (slave).
interface mem_access_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic busReq, busWe, busAck;
   logic [ADDR_W-1:0] busAdr;
   logic [DATA_W-1:0] busWdata, busRdata;
   modport master(output busReq, busWe, busAdr, busWdata, input busAck, busRdata);
   modport slave(input busReq, busWe, busAdr, busWdata, output busAck, busRdata);
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: clearable wait counter flagging the terminal count while enabled.
module mem_wait_counter #(parameter int W = 1) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         tc
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign tc = en && cnt == term;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one CPU load/store at a time over a req/ack bus, stalling the CPU until done.
// Define MEM_ALIGN_CHECK_EN to reject misaligned addresses instead of silently aligning them.
module mem_access_unit import mem_access_pkg::*; #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] memAdr,
   input  logic [DATA_W-1:0] memWriteData,
   output logic [DATA_W-1:0] memReadData,
   output logic              stall,
   output logic              busErr,
   output logic              misaligned,
   mem_access_if.master      bus
);
   localparam int TW = timeoutW(TIMEOUT);
   localparam logic [TW-1:0] TERM = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
   stateT state, nextState;
   logic [ADDR_W-1:0] adrReg;
   logic [DATA_W-1:0] wdReg, rdReg;
   logic weReg, errFlag, misFlag, cntTc, timedOut, memReq, badAlign, unusedAdr;
   assign memReq = memRead | memWrite;
`ifdef MEM_ALIGN_CHECK_EN
   assign badAlign = memAdr[1:0] != 2'b00;
`else
   assign badAlign = 1'b0;
`endif
   assign unusedAdr = ^adrReg[1:0];
   assign timedOut = (TIMEOUT != 0) && cntTc && !bus.busAck;
   mem_wait_counter #(.W(TW)) waitCnt (
      .clk (clk),
      .rst (rst),
      .clr (state != REQ),
      .en  (state == REQ),
      .term(TERM),
      .tc  (cntTc)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         adrReg  <= '0;
         wdReg   <= '0;
         weReg   <= 1'b0;
         rdReg   <= '0;
         errFlag <= 1'b0;
         misFlag <= 1'b0;
      end else begin
         state <= nextState;
         if (state == IDLE && memReq) begin
            adrReg  <= memAdr;
            wdReg   <= memWriteData;
            weReg   <= memWrite;
            errFlag <= 1'b0;
            misFlag <= badAlign;
            if (badAlign) rdReg <= DATA_W'(ERR_DATA);
         end
         if (state == REQ && bus.busAck && !weReg) rdReg <= bus.busRdata;
         if (timedOut) begin
            rdReg   <= DATA_W'(ERR_DATA);
            errFlag <= 1'b1;
         end
      end
   // stall is gated by rst so it drops the instant reset asserts, even with a request held
   always_comb begin
      nextState   = IDLE;
      stall       = 1'b0;
      bus.busReq  = 1'b0;
      busErr      = 1'b0;
      misaligned  = 1'b0;
      case (state)
         IDLE: begin
            stall     = memReq & rst;
            nextState = memReq ? (badAlign ? DONE : REQ) : IDLE;
         end
         REQ: begin
            stall      = 1'b1;
            bus.busReq = 1'b1;
            nextState  = (bus.busAck || timedOut) ? DONE : REQ;
         end
         DONE: begin
            busErr     = errFlag;
            misaligned = misFlag;
         end
         default: nextState = IDLE;
      endcase
   end
   assign bus.busWe    = weReg;
   assign bus.busAdr   = {adrReg[ADDR_W-1:2], 2'b00};
   assign bus.busWdata = wdReg;
   assign memReadData  = rdReg;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench with a memory-level reference model and bus responder.
module tb_mem_access_unit;
   localparam int TIMEOUT = 4;
   logic clk = 0, rst = 1, memRead = 0, memWrite = 0;
   logic [31:0] memAdr = 0, memWriteData = 0, memReadData;
   logic stall, busErr, misaligned;
   mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus();
   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .memAdr(memAdr),
      .memWriteData(memWriteData), .memReadData(memReadData), .stall(stall), .busErr(busErr),
      .misaligned(misaligned), .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] rd; logic err; logic mis; int stalls;} rspT;
   typedef struct {logic [31:0] adr; logic we; logic [31:0] wd; int d;} busT;
   rspT rspQ[$];
   busT busQ[$];
   rspT mon;
   busT cur;
   logic [31:0] refMem[int unsigned];
   logic [31:0] busMem[int unsigned];
   logic [31:0] lastRd = 0;
   int errors = 0, checks = 0, stallCnt = 0, waitCnt = 0;
   bit active = 0;
   logic [31:0] ra;
   bit rw, rr;
   int rd_delay;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] initVal(input logic [31:0] w);
      return (w * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction
   task automatic seed(input logic [31:0] a, input logic [31:0] v);
      refMem[a >> 2] = v;
      busMem[a >> 2] = v;
   endtask
   // memory responder: acks after the delay chosen by the stimulus, throws stray acks while idle
   always @(negedge clk) begin
      bus.busAck = 1'b0;
      if (!bus.busReq) begin
         active = 0;
         bus.busAck = ($urandom_range(3) == 0);
         bus.busRdata = $urandom;
      end else begin
         if (!active) begin
            active = 1;
            waitCnt = 0;
            if (busQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL busUnexpected actual=req adr=%h required=no request", bus.busAdr);
               cur = '{adr: 0, we: 0, wd: 0, d: 1000};
            end else begin
               cur = busQ.pop_front();
               check("busAdr", bus.busAdr, cur.adr);
               check("busWe", {31'b0, bus.busWe}, {31'b0, cur.we});
               if (cur.we) check("busWdata", bus.busWdata, cur.wd);
            end
         end
         if (waitCnt == cur.d) begin
            bus.busAck = 1'b1;
            if (cur.we) busMem[bus.busAdr >> 2] = bus.busWdata;
            else bus.busRdata = busMem.exists(bus.busAdr >> 2) ? busMem[bus.busAdr >> 2] : initVal(bus.busAdr >> 2);
         end
         waitCnt++;
      end
   end
   // response monitor: a held request with stall low is the completion cycle
   always @(negedge clk) begin
      if (!rst || !(memRead || memWrite)) stallCnt = 0;
      else if (stall) stallCnt++;
      else begin
         if (rspQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rspUnexpected actual=done required=no completion at %0t", $time);
         end else begin
            mon = rspQ.pop_front();
            check("memReadData", memReadData, mon.rd);
            check("busErr", {31'b0, busErr}, {31'b0, mon.err});
            check("misaligned", {31'b0, misaligned}, {31'b0, mon.mis});
            check("stallCycles", stallCnt, mon.stalls);
         end
         stallCnt = 0;
      end
   end
   task automatic waitDone();
      int n = 0;
      @(negedge clk);
      while (stall && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (stall) begin
         checks++;
         errors++;
         $display("FAIL doneTimeout actual=stall still high required=completion");
      end
   endtask
   task automatic access(input bit wr, input bit rd, input logic [31:0] adr, input logic [31:0] wd, input int d);
      bit mis = 0;
      logic [31:0] w = adr >> 2;
`ifdef MEM_ALIGN_CHECK_EN
      mis = adr[1:0] != 2'b00;
`endif
      if (mis) begin
         lastRd = 0;
         rspQ.push_back('{rd: 0, err: 0, mis: 1, stalls: 1});
      end else begin
         busQ.push_back('{adr: adr & ~32'h3, we: wr, wd: wd, d: d});
         if (d >= TIMEOUT) begin
            lastRd = 0;
            rspQ.push_back('{rd: 0, err: 1, mis: 0, stalls: 1 + TIMEOUT});
         end else begin
            if (wr) refMem[w] = wd;
            else lastRd = refMem.exists(w) ? refMem[w] : initVal(w);
            rspQ.push_back('{rd: lastRd, err: 0, mis: 0, stalls: d + 2});
         end
      end
      memRead = rd;
      memWrite = wr;
      memAdr = adr;
      memWriteData = wd;
      waitDone();
      @(posedge clk);
      #1;
      memRead = 0;
      memWrite = 0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      bus.busAck = 0;
      bus.busRdata = 0;
      #1 rst = 0;
      #1;
      check("rstBusReq", {31'b0, bus.busReq}, 0);
      check("rstStall", {31'b0, stall}, 0);
      check("rstReadData", memReadData, 0);
      check("rstBusErr", {31'b0, busErr}, 0);
      check("rstMisaligned", {31'b0, misaligned}, 0);
      idle(2);
      rst = 1;
      idle(1);
      seed(32'h20, 32'h12345678);
      access(1, 0, 32'h10, 32'hCAFEBABE, 1);
      idle(1);
      access(0, 1, 32'h20, 32'h0, 0);
      idle(2);
      access(0, 1, 32'h10, 32'h0, 0);
      access(0, 1, 32'h30, 32'h0, 9);
      idle(1);
      busQ.push_back('{adr: 32'h40, we: 0, wd: 0, d: 1000});
      memRead = 1;
      memAdr = 32'h40;
      repeat (3) @(negedge clk);
      #2;
      rst = 0;
      memRead = 0;
      #1;
      check("midRstBusReq", {31'b0, bus.busReq}, 0);
      check("midRstStall", {31'b0, stall}, 0);
      check("midRstReadData", memReadData, 0);
      lastRd = 0;
      @(posedge clk);
      #1 rst = 1;
      idle(1);
      access(0, 1, 32'h20, 32'h0, 2);
      idle(1);
      access(0, 1, 32'h22, 32'h0, 0);
      access(0, 1, 32'h24, 32'h0, 0);
      access(1, 0, 32'h24, 32'h0BADF00D, 0);
      access(0, 1, 32'h24, 32'h0, 1);
      access(1, 1, 32'h28, 32'h11112222, 0);
      access(0, 1, 32'h28, 32'h0, 3);
      for (int i = 0; i < 60; i++) begin
         rw = $urandom_range(1);
         rr = !rw || ($urandom_range(1) == 1);
         ra = ($urandom_range(15) << 2) | (($urandom_range(5) == 0) ? $urandom_range(3) : 0);
         rd_delay = $urandom_range(5);
         access(rw, rr, ra, $urandom, rd_delay);
         if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
      end
      idle(3);
      check("rspQEmpty", rspQ.size(), 0);
      check("busQEmpty", busQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
